// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream and instruction-memory write bus of the loader.
//
// Signals:
//   byte_valid  producer -> loader  byte_data holds a valid program byte
//   byte_data   producer -> loader  program byte (big-endian within a word)
//   byte_ready  loader -> producer  loader can accept a byte this cycle
//   mem_we      loader -> memory    one-cycle write strobe per word
//   mem_addr    loader -> memory    byte address of the write
//   mem_wdata   loader -> memory    word being written
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high; byte_valid while byte_ready is low is ignored
// and the producer keeps the byte until it is accepted.
// mem_addr/mem_wdata are only meaningful while mem_we is high.
//
// Modports: master = loader side, slave = producer/memory side.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory before the CPU
// starts fetching. Bytes arrive over a valid/ready handshake, are assembled
// into big-endian 32-bit words and written to consecutive word addresses
// starting at BASE_ADDR. The CPU is held until a zero terminator word has
// been written.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a running 32-bit sum of the written non-terminator words is
//   kept; after the terminator four more bytes are received as the expected
//   checksum (not written to memory). Match -> DONE, mismatch -> ERROR with
//   checksum_err set. Without it checksum_err is tied low.
//
// Ports:
//   clk           clock, all state changes on posedge
//   reset         asynchronous, active-high reset
//   start         single-cycle pulse; begins a load from IDLE/DONE/ERROR
//   bus           imem_loader_if.master (byte stream in, memory writes out)
//   cpu_hold      keeps the CPU stalled while high
//   done          load completed successfully
//   error         load aborted (overflow or checksum)
//   checksum_err  checksum mismatch flag
//   word_count    words written in the current load, terminator included
//   dbg_state     current FSM state encoding
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h00400000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic          checksum_err,
  output logic [15:0]   word_count,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4,
    S_CHECK = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic [31:0] assembled;
  logic        accept;
  logic        last_byte;
  logic        start_take;
  logic        is_term;
  logic        cap_full;

  // The incoming byte always lands in the low lane; earlier bytes move up,
  // so after four accepts the first byte sits in bits 31:24.
  assign assembled  = {shift, bus.byte_data};
  assign accept     = bus.byte_ready & bus.byte_valid;
  assign last_byte  = accept && (byte_cnt == 2'd3);
  assign start_take = start && ((state == S_IDLE) || (state == S_DONE) ||
                                (state == S_ERROR));
  assign is_term    = (bus.mem_wdata == 32'h0);
  // The word being written would fill the last slot, leaving no room
  // for a terminator.
  assign cap_full   = (({16'h0, word_count} + 32'd1) == 32'(MAX_WORDS));

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        sum_match;
  assign sum_match = (assembled == sum);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_RECV;
      end
      S_RECV: begin
        if (last_byte) state_next = S_WRITE;
      end
      S_WRITE: begin
        // The terminator takes priority over the capacity check: a
        // terminator in the last slot is a complete program.
        if (is_term) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = S_CHECK;
`else
          state_next = S_DONE;
`endif
        end else if (cap_full) begin
          state_next = S_ERROR;
        end else begin
          state_next = S_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (last_byte) state_next = sum_match ? S_DONE : S_ERROR;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    cpu_hold       = 1'b1;
    done           = 1'b0;
    error          = 1'b0;
    case (state)
      S_RECV, S_CHECK: bus.byte_ready = 1'b1;
      S_WRITE:         bus.mem_we     = 1'b1;
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      S_ERROR:         error          = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

  // Byte assembly, write address/data capture and word counting. The write
  // bus is registered at the 4th accept so it is stable for the whole WRITE
  // cycle and holds its value afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt      <= 2'd0;
      shift         <= 24'h0;
      word_count    <= 16'h0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
    end else if (start_take) begin
      byte_cnt   <= 2'd0;
      shift      <= 24'h0;
      word_count <= 16'h0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= assembled[23:0];
      end
      if (last_byte && (state == S_RECV)) begin
        bus.mem_wdata <= assembled;
        bus.mem_addr  <= BASE_ADDR + {14'd0, word_count, 2'b00};
      end
      if ((state == S_WRITE) && (word_count != 16'hFFFF)) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum          <= 32'h0;
      checksum_err <= 1'b0;
    end else if (start_take) begin
      sum          <= 32'h0;
      checksum_err <= 1'b0;
    end else begin
      if ((state == S_WRITE) && !is_term) begin
        sum <= sum + bus.mem_wdata;
      end
      if ((state == S_CHECK) && last_byte && !sum_match) begin
        checksum_err <= 1'b1;
      end
    end
  end
`else
  assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader (MAX_WORDS = 4).
// Expected writes are pushed into exp_q by the stimulus and popped by a
// write monitor; status outputs are compared against hand-computed values.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h00400000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic        checksum_err;
  logic [15:0] word_count;
  logic [2:0]  dbg_state;

  imem_loader_if bus();

  imem_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .checksum_err (checksum_err),
    .word_count   (word_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic        prev_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we must be a single cycle and match the
  // next expected {addr, data}.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      vectors++;
      assert (prev_we === 1'b0) else begin
        miscompares++;
        $error("FAIL we_width: observed mem_we high 2 cycles, expected 1 cycle");
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $error("FAIL unexpected_write: observed addr %h data %h, expected no write",
               bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        assert ({bus.mem_addr, bus.mem_wdata} === mon_exp) else begin
          miscompares++;
          $error("FAIL write: observed addr %h data %h, expected addr %h data %h",
                 bus.mem_addr, bus.mem_wdata, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
    prev_we <= bus.mem_we;
  end

  // ---------------- driver tasks ----------------
  task automatic start_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    bit   ok;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      r = bus.byte_ready;
      @(posedge clk); #1;
      if (r === 1'b1) ok = 1'b1;
    end
    vectors++;
    assert (ok) else begin
      miscompares++;
      $error("FAIL byte_accept: byte %h observed not accepted in 20 cycles, expected accepted", b);
    end
  endtask

  // Sends one word; byte_valid stays high (with junk) through the cycle after
  // the 4th accept, where mem_we is expected exactly when exp_we is set.
  task automatic send_word(input logic [31:0] w, input logic exp_we,
                           input logic [31:0] addr, input int maxgap,
                           input bit poke_start);
    if (exp_we) exp_q.push_back({addr, w});
    for (int k = 0; k < 4; k++) begin
      if (poke_start && k == 1) begin
        bus.byte_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      send_byte(w[31-8*k -: 8], int'($urandom_range(maxgap, 0)));
    end
    bus.byte_data = 8'hEE;
    @(negedge clk);
    check("write_latency", {31'h0, bus.mem_we}, {31'h0, exp_we});
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input bit want_done);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (want_done ? (done === 1'b1) : (error === 1'b1)) got = 1'b1;
      @(posedge clk); #1;
    end
    check(tag, {31'h0, got}, 32'h1);
  endtask

  // Terminator, then (checksum build) the expected checksum word.
  task automatic end_load(input logic [31:0] term_addr, input logic [31:0] csum,
                          input int maxgap);
    send_word(32'h0, 1'b1, term_addr, maxgap, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(csum, 1'b0, 32'h0, maxgap, 1'b0);
`else
    if (csum == 32'h0) check("csum_unused", csum, 32'h0);
`endif
    wait_end("load_done", 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"},   {31'h0, cpu_hold},       32'h1);
    check({tag, "_byte_ready"}, {31'h0, bus.byte_ready}, 32'h0);
    check({tag, "_mem_we"},     {31'h0, bus.mem_we},     32'h0);
    check({tag, "_mem_addr"},   bus.mem_addr,            32'h0);
    check({tag, "_mem_wdata"},  bus.mem_wdata,           32'h0);
    check({tag, "_done"},       {31'h0, done},           32'h0);
    check({tag, "_error"},      {31'h0, error},          32'h0);
    check({tag, "_csum_err"},   {31'h0, checksum_err},   32'h0);
    check({tag, "_word_count"}, {16'h0, word_count},     32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // IDLE ignores offered bytes
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("idle_ready", {31'h0, bus.byte_ready}, 32'h0);
    check("idle_hold",  {31'h0, cpu_hold},       32'h1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;

    // Basic load: 08100003, terminator
    start_load();
    send_word(32'h08100003, 1'b1, 32'h00400000, 0, 1'b0);
    end_load(32'h00400004, 32'h08100003, 0);
    @(negedge clk);
    check("basic_done",       {31'h0, done},       32'h1);
    check("basic_cpu_hold",   {31'h0, cpu_hold},   32'h0);
    check("basic_error",      {31'h0, error},      32'h0);
    check("basic_word_count", {16'h0, word_count}, 32'h2);
    check("basic_addr_hold",  bus.mem_addr,        32'h00400004);
    check("basic_data_hold",  bus.mem_wdata,       32'h00000000);
    @(posedge clk); #1;

    // Restart from DONE; a start pulse mid-word must be ignored
    start_load();
    @(negedge clk);
    check("restart_cpu_hold",   {31'h0, cpu_hold},   32'h1);
    check("restart_done",       {31'h0, done},       32'h0);
    check("restart_word_count", {16'h0, word_count}, 32'h0);
    @(posedge clk); #1;
    send_word(32'h24020005, 1'b1, 32'h00400000, 0, 1'b1);
    end_load(32'h00400004, 32'h24020005, 0);
    @(negedge clk);
    check("restart_done2",  {31'h0, done},       32'h1);
    check("restart_count2", {16'h0, word_count}, 32'h2);
    @(posedge clk); #1;

    // Gaps between bytes; terminator lands in the last slot (MAX_WORDS = 4)
    start_load();
    send_word(32'hDEADBEEF, 1'b1, 32'h00400000, 3, 1'b0);
    send_word(32'h24020005, 1'b1, 32'h00400004, 3, 1'b0);
    send_word(32'h8FBF0014, 1'b1, 32'h00400008, 3, 1'b0);
    end_load(32'h0040000C, 32'h926EBF08, 3);
    @(negedge clk);
    check("gaps_done",       {31'h0, done},       32'h1);
    check("gaps_word_count", {16'h0, word_count}, 32'h4);
    check("gaps_queue",      exp_q.size(),        32'h0);
    @(posedge clk); #1;

    // Overflow: four non-zero words
    start_load();
    send_word(32'h11111111, 1'b1, 32'h00400000, 1, 1'b0);
    send_word(32'h22222222, 1'b1, 32'h00400004, 1, 1'b0);
    send_word(32'h33333333, 1'b1, 32'h00400008, 1, 1'b0);
    send_word(32'h44444444, 1'b1, 32'h0040000C, 1, 1'b0);
    @(negedge clk);
    check("ovf_error",      {31'h0, error},          32'h1);
    check("ovf_cpu_hold",   {31'h0, cpu_hold},       32'h1);
    check("ovf_done",       {31'h0, done},           32'h0);
    check("ovf_word_count", {16'h0, word_count},     32'h4);
    check("ovf_ready",      {31'h0, bus.byte_ready}, 32'h0);
    @(posedge clk); #1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h77;
    repeat (6) begin @(posedge clk); #1; end
    bus.byte_valid = 1'b0;
    check("ovf_queue", exp_q.size(), 32'h0);

    // Start from ERROR, then asynchronous reset after two bytes
    start_load();
    @(negedge clk);
    check("err_restart_error", {31'h0, error},          32'h0);
    check("err_restart_ready", {31'h0, bus.byte_ready}, 32'h1);
    @(posedge clk); #1;
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    bus.byte_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    start_load();
    send_word(32'h11223344, 1'b1, 32'h00400000, 0, 1'b0);
    end_load(32'h00400004, 32'h11223344, 0);
    @(negedge clk);
    check("fresh_word_count", {16'h0, word_count}, 32'h2);
    @(posedge clk); #1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Matching checksum
    start_load();
    send_word(32'h00000001, 1'b1, 32'h00400000, 0, 1'b0);
    send_word(32'h00000002, 1'b1, 32'h00400004, 0, 1'b0);
    end_load(32'h00400008, 32'h00000003, 0);
    @(negedge clk);
    check("csum_ok_err",   {31'h0, checksum_err}, 32'h0);
    check("csum_ok_count", {16'h0, word_count},   32'h3);
    @(posedge clk); #1;
    // Mismatching checksum
    start_load();
    send_word(32'h00000001, 1'b1, 32'h00400000, 0, 1'b0);
    send_word(32'h00000002, 1'b1, 32'h00400004, 0, 1'b0);
    send_word(32'h00000000, 1'b1, 32'h00400008, 0, 1'b0);
    send_word(32'h00000004, 1'b0, 32'h0, 0, 1'b0);
    wait_end("csum_bad_end", 1'b0);
    @(negedge clk);
    check("csum_bad_error", {31'h0, error},        32'h1);
    check("csum_bad_flag",  {31'h0, checksum_err}, 32'h1);
    check("csum_bad_hold",  {31'h0, cpu_hold},     32'h1);
    @(posedge clk); #1;
    start_load();
    @(negedge clk);
    check("csum_clear", {31'h0, checksum_err}, 32'h0);
    @(posedge clk); #1;
`else
    check("csum_tied", {31'h0, checksum_err}, 32'h0);
`endif

    repeat (3) begin @(posedge clk); #1; end
    check("final_queue", exp_q.size(), 32'h0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory fetch interface: streams a program into instruction memory before the PC starts fetching.
- Accepts bytes over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to consecutive word addresses from BASE_ADDR.
- Holds the CPU until a zero terminator word (the halt instruction) has been written.

Parameters:
- BASE_ADDR, 32'h00400000, byte address of the first word written (PC reset value).
- MAX_WORDS, 4096, instruction-memory capacity in words, terminator included.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  incoming program byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the write.
- mem_wdata  out  32  word being written.
- cpu_hold  out  1  keeps the PC/CPU stalled while high.
- done  out  1  load completed successfully.
- error  out  1  load aborted (overflow or checksum).
- checksum_err  out  1  checksum mismatch flag.
- word_count  out  16  words written so far in the current load, terminator included.

Behaviour:
- Reset is asynchronous and active-high.
  - Reset state: IDLE. Byte counter and shift register cleared.
  - Output reset values: cpu_hold=1; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, checksum_err=0, word_count=0.
- States: IDLE, RECV, WRITE, DONE, ERROR (plus CHECK with the optional feature).
- IDLE: cpu_hold=1, byte_ready=0. start -> RECV; clears word_count, byte counter and running sum.
- RECV: byte_ready=1.
  - A byte is accepted only in a cycle where byte_valid and byte_ready are both high.
  - Byte order: 1st accepted byte -> bits 31:24, 2nd -> 23:16, 3rd -> 15:8, 4th -> 7:0.
  - byte_valid without ready is ignored; no byte is lost or duplicated.
  - The 4th accept moves to WRITE on the next edge.
- WRITE: byte_ready=0; mem_we=1 for exactly one cycle.
  - mem_addr = BASE_ADDR + 4*word_count (mod 2^32); mem_wdata = assembled word.
  - At the following edge word_count increments (saturates at 16'hFFFF).
- Next state after WRITE:
  - Word == 32'h0 (terminator, written to memory) -> DONE.
  - Otherwise, word_count+1 == MAX_WORDS -> ERROR (no room for a terminator).
  - Otherwise -> RECV.
- Throughput: minimum 5 cycles per word (4 accept cycles + 1 write cycle). Latency from 4th accept to mem_we is 1 cycle.
- DONE: done=1, cpu_hold=0 (CPU runs). start -> RECV with done=0, cpu_hold=1, counters cleared.
- ERROR: error=1, cpu_hold=1. Exits only on reset or start (start clears error and checksum_err, enters RECV).
- start while in RECV or WRITE is ignored; the load continues.
- Reset mid-load:
  - Partial word discarded; no further mem_we.
  - Words already written remain in memory.
  - CPU stays held (cpu_hold=1).
- mem_addr and mem_wdata hold their last values outside WRITE; consumers qualify them with mem_we.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro:
  - Loader keeps a running 32-bit sum (mod 2^32) of all written non-terminator words.
  - After the terminator write, it enters CHECK and accepts 4 more bytes (same handshake and byte order) as the expected checksum. This word is not written to memory.
  - Match -> DONE. Mismatch -> ERROR with checksum_err=1.
- Without the macro: terminator write -> DONE directly; no CHECK state; checksum_err tied 0.

Test Plan:
- Basic load: reset, start, then bytes 08 10 00 03 / 00 00 00 00 -> mem_we pulses at addr 00400000 data 08100003, then at addr 00400004 data 00000000; then done=1, cpu_hold=0, word_count=2.
- Backpressure and gaps: byte_valid toggled randomly, byte_valid held high during WRITE -> no extra or dropped bytes; each mem_we is exactly 1 cycle; words match the sent stream.
- Overflow: MAX_WORDS=4, send four non-zero words -> ERROR after the 4th write, error=1, cpu_hold=1, no 5th mem_we.
- Reset mid-load: assert reset after 2 bytes of word 1 -> all outputs at reset values immediately (asynchronous); a fresh load then writes from 00400000.
- Restart: after DONE, pulse start and load word 24020005 + terminator -> cpu_hold rises, writes begin at 00400000, done returns to 1.
- Checksum (with IMEM_LOADER_CHECKSUM_EN): words 00000001, 00000002, terminator, checksum 00000003 -> done=1. Same stream with checksum 00000004 -> error=1, checksum_err=1.
